button_conditioner: RTL and testbench

//  Upstream input stage for the sawtooth counter FSM, driving its v_i select input.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/button_conditioner.sv | 168 ++++++++++++++++
 tb/tb_button_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// =============================================================================
// Module      : button_conditioner_pkg
// Description : Shared debounce-FSM state encoding and board-level defaults.
// Revision    : 1.0 - initial release
// =============================================================================
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } btn_state_t;

    // 20 ms debounce and 1 s long-hold at 50 MHz
    localparam int unsigned c_DB_CYCLES_BOARD   = 1_000_000;
    localparam int unsigned c_HOLD_CYCLES_BOARD = 50_000_000;
    localparam int unsigned c_CNT_W_BOARD       = 26;

    // Raw pin level that means "not pressed"
    function automatic logic released_level(input logic active_low);
        return active_low;
    endfunction

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// =============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser with async reset to a chosen level.
// Revision    : 1.0 - initial release
// =============================================================================
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= din_i;
            r_sync <= r_meta;
        end
    end

    assign dout_o = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// =============================================================================
// Module      : button_conditioner
// Description : Synchronise/debounce a push-button, emit press/release/hold
//               pulses and a one-tick-period command for the slow FSM.
// Revision    : 1.0 - initial release
// =============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = c_DB_CYCLES_BOARD,
    parameter int unsigned HOLD_CYCLES    = c_HOLD_CYCLES_BOARD,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W          = c_CNT_W_BOARD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic cmd_o
);

    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);

    logic             w_btn_sync;
    logic             w_sb;
    logic [CNT_W-1:0] w_cnt_inc;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             r_hold_done;
    logic             w_hold_done_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_hold_nxt;

    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_hold;
    logic             r_pend;
    logic             r_cmd;

    sync_2ff #(
        .RESET_VAL (released_level(BTN_ACTIVE_LOW))
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (btn_i),
        .dout_o (w_btn_sync)
    );

    assign w_sb      = BTN_ACTIVE_LOW ? ~w_btn_sync : w_btn_sync;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hcnt_nxt      = r_hcnt;
        w_hold_done_nxt = r_hold_done;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_hold_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sb) begin
                    w_state_nxt = PRESS_DB;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!w_sb) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_db_last) begin
                        w_state_nxt = PRESSED;
                        w_press_nxt = 1'b1;
                    end
                end
            end
            PRESSED: begin
                // hcnt measures cycles with level_o asserted
                if (r_level && (r_hcnt != c_hold_last)) begin
                    w_hcnt_nxt = r_hcnt + CNT_W'(1);
                end
                if ((r_hcnt == c_hold_last) && !r_hold_done) begin
                    w_hold_nxt      = 1'b1;
                    w_hold_done_nxt = 1'b1;
                end
                if (!w_sb) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = r_hcnt;
                end
            end
            RELEASE_DB: begin
                if (w_sb) begin
                    w_state_nxt = PRESSED;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_db_last) begin
                        w_state_nxt     = IDLE;
                        w_release_nxt   = 1'b1;
                        w_hcnt_nxt      = '0;
                        w_hold_done_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_hold_done <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_hold      <= 1'b0;
            r_level     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_hold_done <= w_hold_done_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_hold      <= w_hold_nxt;
            r_level     <= (r_state == PRESSED) || (r_state == RELEASE_DB);
        end
    end

    // A press landing on a tick stays pending and goes out on the next tick
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= 1'b0;
            r_cmd  <= 1'b0;
        end else if (tick_i) begin
            r_cmd  <= r_pend;
            r_pend <= r_press;
        end else if (r_press) begin
            r_pend <= 1'b1;
        end
    end

    assign level_o   = r_level;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign hold_o    = r_hold;
    assign cmd_o     = r_cmd;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// =============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner
//               (DB_CYCLES=4, HOLD_CYCLES=20, active-low button).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic btn  = 1'b1;
    logic tick = 1'b0;
    logic level, press, rel, hold, cmd;
    logic [4:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .DB_CYCLES      (4),
        .HOLD_CYCLES    (20),
        .BTN_ACTIVE_LOW (1'b1),
        .CNT_W          (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_i     (btn),
        .tick_i    (tick),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel),
        .hold_o    (hold),
        .cmd_o     (cmd)
    );

    always #5 clk = ~clk;

    assign outs = {level, press, rel, hold, cmd};

    // Expected {level, press, release, hold} for a press held from cycle s for
    // d cycles (cycle n = value seen after the n-th rising edge of the run).
    function automatic logic [3:0] pattern(input int i, input int s, input int d,
                                           input int hold_off);
        pattern = {(i >= s + 7) && (i <= s + d + 6),
                   i == s + 6,
                   i == s + d + 6,
                   (hold_off > 0) && (i == s + hold_off)};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        btn  = 1'b1;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        btn  = 1'b1;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 5'b0);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
        end
        btn  = 1'b0;
        tick = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_dominates: got %b expected %b", outs, 5'b0);
        end
        btn  = 1'b1;
        tick = 1'b0;
        rst  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, outs, 5'b0);
            end
        end
    endtask

    task automatic test_press();
        logic [4:0] exp;
        apply_reset();
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            exp = {pattern(i, 0, 10, 0), 1'b0};
            n_checks++;
            if (outs !== exp) begin
                n_errors++;
                $display("FAIL press cycle %0d: outs(lvl,prs,rel,hld,cmd) got %b expected %b",
                         i, outs, exp);
            end
            btn = !(i < 10);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i <= 36; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 5'b0) begin
                n_errors++;
                $display("FAIL bounce cycle %0d: got %b expected %b", i, outs, 5'b0);
            end
            btn = (i < 30) ? logic'(((i / 2) % 2) != 0) : 1'b1;
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL bounce_final_state: got %0d expected %0d", dut.r_state, IDLE);
        end
    endtask

    task automatic test_hold();
        logic [4:0] exp;
        apply_reset();
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            exp = {pattern(i, 0, 40, 27), 1'b0};
            n_checks++;
            if (outs !== exp) begin
                n_errors++;
                $display("FAIL hold cycle %0d: outs(lvl,prs,rel,hld,cmd) got %b expected %b",
                         i, outs, exp);
            end
            btn = !(i < 40);
        end
    endtask

    task automatic test_cmd_handoff();
        logic [4:0] exp;
        apply_reset();
        for (int i = 0; i <= 205; i++) begin
            @(negedge clk);
            exp = {pattern(i, 0, 10, 0) | pattern(i, 110, 8, 0) | pattern(i, 130, 8, 0),
                   ((i >= 50) && (i <= 99)) || ((i >= 150) && (i <= 199))};
            n_checks++;
            if (outs !== exp) begin
                n_errors++;
                $display("FAIL cmd_handoff cycle %0d: got %b expected %b", i, outs, exp);
            end
            btn  = !((i < 10) || ((i >= 110) && (i < 118)) || ((i >= 130) && (i < 138)));
            tick = ((i % 50) == 49);
        end
        tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        apply_reset();
        for (int i = 0; i <= 35; i++) begin
            @(negedge clk);
            exp = {pattern(i, 0, 10, 0), (i >= 21) && (i <= 30)};
            n_checks++;
            if (outs !== exp) begin
                n_errors++;
                $display("FAIL press_on_tick cycle %0d: got %b expected %b", i, outs, exp);
            end
            btn  = !(i < 10);
            tick = (i == 6) || (i == 20) || (i == 30);
        end
        tick = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] exp;
        int stop;
        for (int ph = 0; ph < 2; ph++) begin
            stop = (ph == 0) ? 4 : 25;
            apply_reset();
            for (int i = 0; i <= stop; i++) begin
                @(negedge clk);
                exp = {pattern(i, 0, 100, 0), (ph == 1) && (i >= 13)};
                n_checks++;
                if (outs !== exp) begin
                    n_errors++;
                    $display("FAIL async_rst_pre ph%0d cycle %0d: got %b expected %b",
                             ph, i, outs, exp);
                end
                if (i < stop) begin
                    btn  = 1'b0;
                    tick = (i == 12);
                end
            end
            #2;
            rst  = 1'b1;
            btn  = 1'b1;
            tick = 1'b0;
            #1;
            n_checks++;
            if (outs !== 5'b0) begin
                n_errors++;
                $display("FAIL async_rst_immediate ph%0d: got %b expected %b", ph, outs, 5'b0);
            end
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                n_checks++;
                if (outs !== 5'b0) begin
                    n_errors++;
                    $display("FAIL async_rst_post ph%0d cycle %0d: got %b expected %b",
                             ph, i, outs, 5'b0);
                end
                tick = ((i % 10) == 5);
            end
            tick = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_hold();
        test_cmd_handoff();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_button_conditioner
`default_nettype wire
